// File: rtl/free_reg_list.sv
// Free-register list: a window of OUT_W free physical register indices for rename,
// backed by a free bitmap that refills vacated slots lowest-index-first.
module free_reg_list #(
    parameter int NUM_PHYS_REGS = 128,
    parameter int NUM_ARCH_REGS = 32,
    parameter int INSTR_Q_WIDTH = 2,
    parameter int FREE_W        = 2,
    parameter int RESERVED      = NUM_ARCH_REGS + 1,
    localparam int OUT_W  = 8 * INSTR_Q_WIDTH,
    localparam int PREG_W = $clog2(NUM_PHYS_REGS),
    localparam int CNT_W  = $clog2(NUM_PHYS_REGS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_N_in,
    input  logic [OUT_W-1:0]          frl_ready,
    output logic [OUT_W*PREG_W-1:0]   free_register_data,
    output logic                      frl_valid,
    input  logic [FREE_W-1:0]         commit_free_valid,
    input  logic [FREE_W*PREG_W-1:0]  commit_free_reg,
    output logic [CNT_W-1:0]          free_count,
    output logic                      err_double_free,
    output logic                      err_bad_consume
);

    localparam logic [NUM_PHYS_REGS-1:0] BM_RST = {NUM_PHYS_REGS{1'b1}} << (RESERVED + OUT_W);

    logic [PREG_W-1:0]        r_slot_reg [OUT_W];
    logic [OUT_W-1:0]         r_slot_vld;
    logic [NUM_PHYS_REGS-1:0] r_free_bm;
    logic [CNT_W-1:0]         r_free_count;
    logic                     r_err_dbl;
    logic                     r_err_bad;

    logic [PREG_W-1:0]        w_slot_reg_nxt [OUT_W];
    logic [OUT_W-1:0]         w_slot_vld_nxt;
    logic [NUM_PHYS_REGS-1:0] w_bm_avail;
    logic [NUM_PHYS_REGS-1:0] w_bm_nxt;
    logic [OUT_W-1:0]         w_vacated;
    logic                     w_found;
    logic [PREG_W-1:0]        w_idx;
    logic                     w_dup;
    logic                     w_dbl;
    logic [CNT_W-1:0]         w_n_freed;
    logic [CNT_W-1:0]         w_free_count_nxt;

    // NOTE: every variable written in always_comb gets a default first, so no path
    // through the loops below can leave a value held and infer a latch.
    always_comb begin
        w_vacated      = frl_ready & r_slot_vld;
        w_slot_vld_nxt = r_slot_vld & ~w_vacated;
        w_slot_reg_nxt = r_slot_reg;
        w_bm_avail     = r_free_bm;
        w_found        = 1'b0;

        // Refill draws only from the bitmap as it stood at the start of the cycle.
        for (int k = 0; k < OUT_W; k++) begin
            if (!w_slot_vld_nxt[k]) begin
                w_found = 1'b0;
                for (int i = 0; i < NUM_PHYS_REGS; i++) begin
                    if (!w_found && w_bm_avail[i]) begin
                        w_slot_reg_nxt[k] = PREG_W'(i);
                        w_slot_vld_nxt[k] = 1'b1;
                        w_bm_avail[i]     = 1'b0;
                        w_found           = 1'b1;
                    end
                end
            end
        end

        w_bm_nxt  = w_bm_avail;
        w_idx     = '0;
        w_dup     = 1'b0;
        w_dbl     = 1'b0;
        w_n_freed = '0;
        for (int j = 0; j < FREE_W; j++) begin
            if (commit_free_valid[j]) begin
                w_idx = commit_free_reg[j*PREG_W +: PREG_W];
                w_dup = 1'b0;
                if (int'(w_idx) >= NUM_PHYS_REGS) begin
                    w_dup = 1'b1;
                end else if (r_free_bm[w_idx]) begin
                    w_dup = 1'b1;
                end
                for (int k = 0; k < OUT_W; k++) begin
                    if (r_slot_vld[k] && r_slot_reg[k] == w_idx) w_dup = 1'b1;
                end
                for (int jj = 0; jj < FREE_W; jj++) begin
                    if (jj < j && commit_free_valid[jj] &&
                        commit_free_reg[jj*PREG_W +: PREG_W] == w_idx) w_dup = 1'b1;
                end
                if (w_dup) begin
                    w_dbl = 1'b1;
                end else begin
                    w_bm_nxt[w_idx] = 1'b1;
                    w_n_freed       = w_n_freed + CNT_W'(1);
                end
            end
        end

        w_free_count_nxt = r_free_count - CNT_W'($countones(w_vacated)) + w_n_freed;
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_N_in) begin
        if (!rst_N_in) begin
            // NOTE: the slot array and bitmap are reset explicitly; they hold the
            // free-list contents, so their power-up value is architecturally visible.
            for (int k = 0; k < OUT_W; k++) begin
                r_slot_reg[k] <= PREG_W'(RESERVED + k);
            end
            r_slot_vld   <= '1;
            r_free_bm    <= BM_RST;
            r_free_count <= CNT_W'(NUM_PHYS_REGS - RESERVED);
            r_err_dbl    <= 1'b0;
            r_err_bad    <= 1'b0;
        end else begin
            r_slot_reg   <= w_slot_reg_nxt;
            r_slot_vld   <= w_slot_vld_nxt;
            r_free_bm    <= w_bm_nxt;
            r_free_count <= w_free_count_nxt;
            r_err_dbl    <= r_err_dbl | w_dbl;
            r_err_bad    <= r_err_bad | (|(frl_ready & ~r_slot_vld));
        end
    end

    always_comb begin
        free_register_data = '0;
        for (int k = 0; k < OUT_W; k++) begin
            free_register_data[k*PREG_W +: PREG_W] = r_slot_reg[k];
        end
    end

    assign frl_valid       = &r_slot_vld;
    assign free_count      = r_free_count;
    assign err_double_free = r_err_dbl;
    assign err_bad_consume = r_err_bad;

endmodule

// File: tb/tb_free_reg_list.sv
// Directed bench for free_reg_list: a vector table from reset plus hand sequences
// for exhaustion, double frees and asynchronous reset.
module tb_free_reg_list;

    localparam int OUT_W  = 16;
    localparam int PREG_W = 7;
    localparam int FREE_W = 2;
    localparam int CNT_W  = 8;

    logic                     clk;
    logic                     rst_N_in;
    logic [OUT_W-1:0]         frl_ready;
    logic [OUT_W*PREG_W-1:0]  free_register_data;
    logic                     frl_valid;
    logic [FREE_W-1:0]        commit_free_valid;
    logic [FREE_W*PREG_W-1:0] commit_free_reg;
    logic [CNT_W-1:0]         free_count;
    logic                     err_double_free;
    logic                     err_bad_consume;

    int n_checks = 0;
    int n_errors = 0;

    free_reg_list dut (
        .clk                (clk),
        .rst_N_in           (rst_N_in),
        .frl_ready          (frl_ready),
        .free_register_data (free_register_data),
        .frl_valid          (frl_valid),
        .commit_free_valid  (commit_free_valid),
        .commit_free_reg    (commit_free_reg),
        .free_count         (free_count),
        .err_double_free    (err_double_free),
        .err_bad_consume    (err_bad_consume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] ready;
        logic [1:0]  fv;
        int          fr0;
        int          fr1;
        int          sa;
        int          va;
        int          sb;
        int          vb;
        int          vld;
        int          cnt;
        int          dbl;
        int          bad;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int slot(input int k);
        return int'(free_register_data[k*PREG_W +: PREG_W]);
    endfunction

    task automatic drive(input logic [15:0] ready, input logic [1:0] fv, input int fr0, input int fr1);
        frl_ready         = ready;
        commit_free_valid = fv;
        commit_free_reg   = {PREG_W'(fr1), PREG_W'(fr0)};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between clock edges.
    task automatic do_reset();
        drive(16'h0, 2'b00, 0, 0);
        rst_N_in = 1'b0;
        #3;
        rst_N_in = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_slot0"}, slot(0), 33);
        check({tag, "_slot15"}, slot(15), 48);
        check({tag, "_valid"}, int'(frl_valid), 1);
        check({tag, "_count"}, int'(free_count), 95);
        check({tag, "_dbl"}, int'(err_double_free), 0);
        check({tag, "_bad"}, int'(err_bad_consume), 0);
    endtask

    initial begin
        //           name        ready     fv     fr0 fr1 sa  va  sb  vb  vld cnt dbl bad
        vecs[0] = '{"idle",     16'h0000, 2'b00, 0,  0,  0,  33, 15, 48, 1,  95, 0,  0};
        vecs[1] = '{"sparse",   16'h0022, 2'b00, 0,  0,  1,  49, 5,  50, 1,  93, 0,  0};
        vecs[2] = '{"full",     16'hFFFF, 2'b00, 0,  0,  0,  51, 15, 66, 1,  77, 0,  0};
        vecs[3] = '{"free40",   16'h0000, 2'b01, 40, 0,  0,  51, 15, 66, 1,  78, 0,  0};
        vecs[4] = '{"refill40", 16'h0001, 2'b00, 0,  0,  0,  40, 1,  52, 1,  77, 0,  0};
        vecs[5] = '{"dupfree",  16'h0000, 2'b11, 33, 33, 0,  40, 1,  52, 1,  78, 1,  0};
        vecs[6] = '{"refill33", 16'h0002, 2'b00, 0,  0,  1,  33, 2,  53, 1,  77, 1,  0};
        vecs[7] = '{"freecons", 16'h0004, 2'b01, 34, 0,  2,  67, 1,  33, 1,  77, 1,  0};
        vecs[8] = '{"refill34", 16'h0008, 2'b00, 0,  0,  3,  34, 2,  67, 1,  76, 1,  0};

        drive(16'h0, 2'b00, 0, 0);
        rst_N_in = 1'b0;
        #12;
        check("valid_in_reset", int'(frl_valid), 1);
        check("count_in_reset", int'(free_count), 95);
        rst_N_in = 1'b1;
        step();
        check_reset_state("t1");

        // Table run starts from a fresh reset.
        do_reset();
        for (int v = 0; v < 9; v++) begin
            drive(vecs[v].ready, vecs[v].fv, vecs[v].fr0, vecs[v].fr1);
            step();
            check({vecs[v].name, "_slotA"}, slot(vecs[v].sa), vecs[v].va);
            check({vecs[v].name, "_slotB"}, slot(vecs[v].sb), vecs[v].vb);
            check({vecs[v].name, "_valid"}, int'(frl_valid), vecs[v].vld);
            check({vecs[v].name, "_count"}, int'(free_count), vecs[v].cnt);
            check({vecs[v].name, "_dbl"}, int'(err_double_free), vecs[v].dbl);
            check({vecs[v].name, "_bad"}, int'(err_bad_consume), vecs[v].bad);
        end

        // Exhaust the list, then watch a single free refill with one cycle of latency.
        do_reset();
        drive(16'hFFFF, 2'b00, 0, 0);
        for (int c = 0; c < 4; c++) step();
        check("ex4_slot0", slot(0), 97);
        check("ex4_count", int'(free_count), 31);
        check("ex4_valid", int'(frl_valid), 1);
        step();
        check("ex5_slot14", slot(14), 127);
        check("ex5_count", int'(free_count), 15);
        check("ex5_valid", int'(frl_valid), 0);
        drive(16'h7FFF, 2'b00, 0, 0);
        step();
        check("ex6_count", int'(free_count), 0);
        check("ex6_valid", int'(frl_valid), 0);
        check("ex6_bad", int'(err_bad_consume), 0);
        drive(16'h0000, 2'b01, 40, 0);
        step();
        check("ex_free_count", int'(free_count), 1);
        check("ex_free_not_yet", int'(slot(0) == 40), 0);
        drive(16'h0000, 2'b00, 0, 0);
        step();
        check("ex_refill_slot0", slot(0), 40);
        check("ex_refill_valid", int'(frl_valid), 0);
        check("ex_refill_count", int'(free_count), 1);
        drive(16'h0002, 2'b00, 0, 0);
        step();
        check("bad_consume_flag", int'(err_bad_consume), 1);
        check("bad_consume_count", int'(free_count), 1);
        drive(16'h0000, 2'b00, 0, 0);
        #2;
        rst_N_in = 1'b0;
        #1;
        check_reset_state("rst_after_err");
        rst_N_in = 1'b1;

        // Freeing a slot-resident register.
        do_reset();
        drive(16'h0000, 2'b10, 0, 33);
        step();
        check("resident_dbl", int'(err_double_free), 1);
        check("resident_count", int'(free_count), 95);

        // Freeing a register already in the bitmap on both ports.
        do_reset();
        drive(16'h0000, 2'b11, 100, 100);
        step();
        check("bm_dup_dbl", int'(err_double_free), 1);
        check("bm_dup_count", int'(free_count), 95);

        // Two distinct legal frees in one cycle.
        do_reset();
        drive(16'h0003, 2'b00, 0, 0);
        step();
        check("pair_consume_count", int'(free_count), 93);
        drive(16'h0000, 2'b11, 33, 34);
        step();
        check("pair_free_count", int'(free_count), 95);
        check("pair_free_dbl", int'(err_double_free), 0);

        // Asynchronous reset in the middle of full-consume traffic.
        do_reset();
        drive(16'hFFFF, 2'b00, 0, 0);
        step();
        step();
        check("burst_slot0", slot(0), 65);
        #2;
        rst_N_in = 1'b0;
        #1;
        check_reset_state("t6");
        drive(16'h0000, 2'b00, 0, 0);
        #1;
        rst_N_in = 1'b1;
        step();
        check("t6_after_count", int'(free_count), 95);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
